// File: rtl/kw4281_monitor_8.sv
`default_nettype none
// ============================================================================
//  Module   : kw4281_monitor_8
//  Purpose  : Passive monitor for a multiplexed 4-digit KW4281 7-segment
//             display bus. It waits for the anode and segment lines to
//             settle, then captures one digit per slot. When all four slots
//             are held, it rebuilds the signed 8-bit value that the display
//             shows.
//  Ports    : clk      - system clock, rising edge
//             rst_i    - asynchronous active-high reset
//             an_i     - anode select, active-low one-hot (bit 3 = leftmost)
//             seg_i    - segments, active-low {g,f,e,d,c,b,a}
//             value_o  - signed value of the last valid frame
//             valid_o  - one-cycle pulse, value_o updated
//             err_o    - one-cycle pulse, complete frame rejected
//  Revision : 1.0  initial release
// ============================================================================
module kw4281_monitor_8 #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [3:0]        an_i,
    input  logic [6:0]        seg_i,
    output logic signed [7:0] value_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam int             c_CW         = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(SETTLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_PRE   = c_CW'(SETTLE_CYCLES - 2);

    localparam logic [3:0] c_CODE_MINUS   = 4'd10;
    localparam logic [3:0] c_CODE_BLANK   = 4'd11;
    localparam logic [3:0] c_CODE_INVALID = 4'd15;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_EVAL    = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_an;
    logic [3:0]      r_an_d;
    logic [6:0]      r_seg;
    logic [6:0]      r_seg_d;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_mask;
    logic [3:0][3:0] r_code;

    logic            w_same;
    logic            w_onehot;
    logic [1:0]      w_slot;
    logic            w_capture;
    logic [3:0]      w_mask_base;
    logic [9:0]      w_mag;
    logic            w_digits_ok;
    logic            w_frame_ok;
    logic [7:0]      w_value;

    function automatic logic [3:0] f_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b0111111: code = c_CODE_MINUS;
            7'b1111111: code = c_CODE_BLANK;
            default:    code = c_CODE_INVALID;
        endcase
        return code;
    endfunction

    // The current registered sample is compared with the one before it. Any
    // difference restarts the dwell count.
    assign w_same = (r_an == r_an_d) && (r_seg == r_seg_d);

    always_comb begin
        w_onehot = 1'b1;
        w_slot   = 2'd0;
        case (r_an_d)
            4'b1110: w_slot = 2'd0;
            4'b1101: w_slot = 2'd1;
            4'b1011: w_slot = 2'd2;
            4'b0111: w_slot = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    // A capture fires on the edge where the counter reaches its saturation
    // value. Because the counter then stays saturated, the same stable bus is
    // never sampled twice.
    assign w_capture = w_same && (r_cnt == c_CNT_PRE) && w_onehot;

    // Leaving EVAL clears the mask first. A capture on that same edge
    // therefore starts the next frame.
    assign w_mask_base = (r_state == S_EVAL) ? 4'b0000 : r_mask;

    assign w_mag = 10'(r_code[2]) * 10'd100
                 + 10'(r_code[1]) * 10'd10
                 + 10'(r_code[0]);

    assign w_digits_ok = (r_code[2] <= 4'd9) && (r_code[1] <= 4'd9) && (r_code[0] <= 4'd9);

    // "-000" fails the lower bound on the minus branch.
    assign w_frame_ok = w_digits_ok &&
                        (((r_code[3] == c_CODE_BLANK) && (w_mag <= 10'd127)) ||
                         ((r_code[3] == c_CODE_MINUS) && (w_mag >= 10'd1) && (w_mag <= 10'd128)));

    assign w_value = (r_code[3] == c_CODE_MINUS) ? 8'(10'd0 - w_mag) : w_mag[7:0];

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_COLLECT;
            r_an    <= 4'b1111;
            r_an_d  <= 4'b1111;
            r_seg   <= 7'b1111111;
            r_seg_d <= 7'b1111111;
            r_cnt   <= '0;
            r_mask  <= 4'b0000;
            r_code  <= {4{c_CODE_BLANK}};
            value_o <= 8'sd0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            r_an    <= an_i;
            r_seg   <= seg_i;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
            valid_o <= 1'b0;
            err_o   <= 1'b0;

            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_mask         <= w_mask_base | (4'b0001 << w_slot);
                r_code[w_slot] <= f_decode(r_seg_d);
            end else begin
                r_mask <= w_mask_base;
            end

            case (r_state)
                S_COLLECT: begin
                    if (r_mask == 4'b1111) begin
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_state <= S_COLLECT;
                    if (w_frame_ok) begin
                        value_o <= w_value;
                        valid_o <= 1'b1;
                    end else begin
                        err_o   <= 1'b1;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/kw4281_monitor_8.md
KW4281_MONITOR_8 -- requirements
Module: kw4281_monitor_8

Interface
REQ-001 Parameter SETTLE_CYCLES (int, default 16): consecutive cycles that an_i/seg_i must hold before a digit is sampled; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 an_i  input  4  digit anode select, active-low one-hot; bit k selects digit slot k, slot 3 is leftmost.
REQ-005 seg_i  input  7  segment pattern, active-low, {g,f,e,d,c,b,a}.
REQ-006 value_o  output  8  signed two's-complement value of the last valid frame.
REQ-007 valid_o  output  1  one-cycle pulse; value_o was updated this cycle.
REQ-008 err_o  output  1  one-cycle pulse; a complete frame was rejected.

Function
REQ-009 The block SHALL reconstruct the signed 8-bit value shown on a multiplexed 4-digit KW4281 display by sampling the an_i/seg_i bus.
REQ-010 Inputs SHALL be registered once, and the block SHALL compare each registered sample with the previous one; any difference SHALL clear the stability counter to 0.
REQ-011 The stability counter SHALL saturate at SETTLE_CYCLES-1 and SHALL NOT wrap.
REQ-012 When the counter first reaches SETTLE_CYCLES-1 and an_i is exactly one-hot low, the block SHALL decode seg_i into slot k, set capture-mask bit k, and SHALL NOT sample again until the bus changes.
REQ-013 an_i equal to 4'b1111, or any non-one-hot value, SHALL NOT be captured; the mask SHALL be left unchanged.
REQ-014 A re-capture of a slot already in the mask SHALL overwrite that slot's code.
REQ-015 Decode table (seg_i to code): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0111111=MINUS, 1111111=BLANK; all other patterns SHALL decode to INVALID.
REQ-016 FSM states: COLLECT (mask not full), EVAL (one cycle). COLLECT SHALL move to EVAL in the cycle after the mask becomes 4'b1111; EVAL SHALL always return to COLLECT with the mask cleared.
REQ-017 In EVAL, the frame SHALL be valid only if: slot3 is MINUS or BLANK; slots 2..0 are each 0-9; mag = 100*s2 + 10*s1 + s0 (computed at 10 bits) is at most 127 for BLANK or 1..128 for MINUS.
REQ-018 For a valid frame, value_o SHALL be set to mag (BLANK) or -mag (MINUS), and valid_o SHALL be 1 in the same cycle.
REQ-019 For an invalid frame, err_o SHALL pulse and value_o SHALL hold its value; "-000" SHALL be treated as invalid.
REQ-020 valid_o and err_o SHALL never be high together, and each SHALL last exactly one cycle.
REQ-021 A capture that occurs in the EVAL cycle SHALL be applied after the mask clear, so that capture starts the next frame.
REQ-022 Latency: valid_o/err_o SHALL assert exactly 2 cycles after the cycle in which the fourth slot is captured.

Reset
REQ-023 While rst_i is high: value_o = 0, valid_o = 0, err_o = 0, mask = 0, counter = 0, slot codes = BLANK, FSM = COLLECT.
REQ-024 Reset asserted mid-frame or in EVAL SHALL discard the partial frame with no pulse.
REQ-025 The first capture after rst_i deasserts SHALL require a full SETTLE_CYCLES dwell.

Verification
REQ-026 Drive slots 3..0 = BLANK,1,2,7, each held 20 cycles, with SETTLE_CYCLES=16 -> valid_o pulse, value_o = 8'sd127 (0x7F).
REQ-027 Drive slots = MINUS,1,2,8 -> valid_o pulse, value_o = -128 (0x80); then MINUS,1,2,9 -> err_o pulse, value_o stays 0x80.
REQ-028 Hold slot 0 for only 10 cycles (fewer than SETTLE_CYCLES), while the other slots are held 20 cycles -> no pulse, mask = 4'b1110.
REQ-029 Drive slot 1 with pattern 1010101 -> err_o at frame end; an_i = 4'b1001 held 40 cycles -> no capture.
REQ-030 Assert rst_i after three slots are captured, then deliver a full BLANK,0,4,2 frame -> exactly one valid_o pulse, value_o = 42, and no earlier pulse.
